unary_binary_decode: RTL and testbench
======================================

Name: unary_binary_decode

Overview:
- Serial de-binarizer for the HEVC unary and truncated-unary (TRU) bin strings produced by the binarization encoder.
- Accepts one bin per cycle over a valid/ready handshake and counts leading ones until the string terminates.
- Returns the reconstructed syntax-element value and the number of bins consumed.
- Sits between the arithmetic-decoder bin output and the syntax-element parser.

Parameters:
- VALUE_WIDTH, 8, width of the decoded value; the unary count saturates at 2^VALUE_WIDTH-1.
- CMAX_WIDTH, 3, width of the TRU cMax input.
- LEN_WIDTH, 9, width of Bin_length_o; must be at least VALUE_WIDTH+1.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- start_i  in  1  pulse that begins a decode; sampled only in IDLE.
- cMax  in  CMAX_WIDTH  TRU maximum; latched at start.
- sel  in  1  mode, latched at start: 0 = TRU, 1 = plain unary.
- bin_i  in  1  incoming bin.
- bin_valid_i  in  1  bin_i is valid this cycle.
- bin_ready_o  out  1  decoder accepts a bin this cycle.
- Value_o  out  VALUE_WIDTH  decoded value; held until the next start.
- Bin_length_o  out  LEN_WIDTH  number of bins consumed; held until the next start.
- Done_o  out  1  one-cycle pulse; Value_o and Bin_length_o are valid in this cycle.
- busy_o  out  1  high in DECODE and DONE.
- err_o  out  1  unary overflow flag; qualified by Done_o and held until the next start.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - State goes to IDLE.
  - All outputs go to 0: Value_o, Bin_length_o, Done_o, bin_ready_o, busy_o, err_o.
  - The count register clears.
  - A reset during DECODE abandons the decode; any partial count is discarded.
- States: IDLE, DECODE, DONE.
- IDLE:
  - On start_i=1, latch sel and cMax, clear the count, and clear err_o.
  - If sel=0 and cMax=0, go to DONE with Value_o=0 and Bin_length_o=0; no bins are consumed.
  - Otherwise go to DECODE.
  - start_i at cycle t gives bin_ready_o=1 at cycle t+1.
- DECODE:
  - bin_ready_o=1 combinationally from state. A bin is accepted when bin_valid_i and bin_ready_o are both 1.
  - Accepted bin = 1, not terminating: count increments.
  - Accepted bin = 0: terminates. Value_o=count, Bin_length_o=count+1.
  - TRU: terminates when an accepted 1 brings count+1 up to cMax. Value_o=cMax, Bin_length_o=cMax, and no trailing zero is consumed.
  - Unary: if count = 2^VALUE_WIDTH-1 and the accepted bin is 1, terminate with Value_o=2^VALUE_WIDTH-1, Bin_length_o=2^VALUE_WIDTH, err_o=1.
  - Cycles with bin_valid_i=0 are stalls; state and count are held.
  - On termination, go to DONE.
- DONE:
  - Done_o=1 for exactly one cycle, bin_ready_o=0, then return to IDLE.
  - Latency: the terminating bin accepted at cycle k gives Done_o at cycle k+1.
- start_i is ignored while busy_o=1. start_i in the same cycle that DONE returns to IDLE is also ignored, because the FSM is still in DONE that cycle.
- cMax and sel changes after the start cycle have no effect on the current decode.
- Arithmetic:
  - count is VALUE_WIDTH bits.
  - Bin_length_o is computed at LEN_WIDTH bits, so count+1 never wraps.
  - The TRU compare zero-extends cMax to VALUE_WIDTH.

Test Plan:
- sel=0, cMax=3, bins 1,1,0 valid back-to-back → Value_o=2, Bin_length_o=3, Done_o one cycle after the third bin; bin_ready_o=0 during DONE.
- sel=0, cMax=3, bins 1,1,1 followed by a held 0 → Value_o=3, Bin_length_o=3, Done_o after the third bin; the 0 is not consumed.
- sel=1, bins 1×7 then 0, with bin_valid_i deasserted for 2 cycles after bin 3 → Value_o=7, Bin_length_o=8; count is held across the stall.
- sel=0, cMax=0 start → Done_o at t+1 with Value_o=0 and Bin_length_o=0; bin_ready_o never rises.
- sel=1, VALUE_WIDTH=8, 256 consecutive 1s → err_o=1, Value_o=255, Bin_length_o=256 with Done_o; start_i pulsed mid-decode is ignored.
- rst_n=0 for one cycle after 2 bins of a unary decode → next cycle is IDLE with all outputs 0; a new decode of bins 0 gives Value_o=0, Bin_length_o=1.

Source files
------------

// File: rtl/unary_binary_decode.sv
// Serial de-binarizer for HEVC unary / truncated-unary bin strings.
// Counts leading ones one bin per cycle and reports the value and bin count.
module unary_binary_decode #(
  parameter int VALUE_WIDTH = 8,
  parameter int CMAX_WIDTH  = 3,
  parameter int LEN_WIDTH   = 9
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic [CMAX_WIDTH-1:0]  cMax,
  input  logic                   sel,
  input  logic                   bin_i,
  input  logic                   bin_valid_i,
  output logic                   bin_ready_o,
  output logic [VALUE_WIDTH-1:0] Value_o,
  output logic [LEN_WIDTH-1:0]   Bin_length_o,
  output logic                   Done_o,
  output logic                   busy_o,
  output logic                   err_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [VALUE_WIDTH-1:0] COUNT_MAX = {VALUE_WIDTH{1'b1}};

  state_t                 state_q;
  logic                   sel_q;
  logic [CMAX_WIDTH-1:0]  cmax_q;
  logic [VALUE_WIDTH-1:0] count_q;
  logic [VALUE_WIDTH-1:0] value_q;
  logic [LEN_WIDTH-1:0]   len_q;
  logic                   done_q;
  logic                   busy_q;
  logic                   ready_q;
  logic                   err_q;

  logic [VALUE_WIDTH-1:0] count_inc_s;
  logic [VALUE_WIDTH-1:0] cmax_ext_s;
  logic [LEN_WIDTH-1:0]   len_inc_s;

  // count+1 is formed at LEN_WIDTH for the length so the saturated case reports 2^VALUE_WIDTH
  assign count_inc_s = count_q + VALUE_WIDTH'(1);
  assign cmax_ext_s  = VALUE_WIDTH'(cmax_q);
  assign len_inc_s   = LEN_WIDTH'(count_q) + LEN_WIDTH'(1);

  assign bin_ready_o  = ready_q;
  assign Value_o      = value_q;
  assign Bin_length_o = len_q;
  assign Done_o       = done_q;
  assign busy_o       = busy_q;
  assign err_o        = err_q;

  // Decode FSM; all outputs are registered alongside the state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sel_q   <= 1'b0;
      cmax_q  <= {CMAX_WIDTH{1'b0}};
      count_q <= {VALUE_WIDTH{1'b0}};
      value_q <= {VALUE_WIDTH{1'b0}};
      len_q   <= {LEN_WIDTH{1'b0}};
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            sel_q   <= sel;
            cmax_q  <= cMax;
            count_q <= {VALUE_WIDTH{1'b0}};
            value_q <= {VALUE_WIDTH{1'b0}};
            len_q   <= {LEN_WIDTH{1'b0}};
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            // TRU with cMax=0 has an empty bin string
            if (!sel && (cMax == {CMAX_WIDTH{1'b0}})) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              ready_q <= 1'b0;
            end else begin
              state_q <= S_DECODE;
              ready_q <= 1'b1;
            end
          end else begin
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
          end
        end
        S_DECODE: begin
          if (bin_valid_i) begin
            if (!bin_i) begin
              value_q <= count_q;
              len_q   <= len_inc_s;
              state_q <= S_DONE;
              done_q  <= 1'b1;
              ready_q <= 1'b0;
            end else if (!sel_q && (count_inc_s == cmax_ext_s)) begin
              value_q <= cmax_ext_s;
              len_q   <= LEN_WIDTH'(cmax_q);
              state_q <= S_DONE;
              done_q  <= 1'b1;
              ready_q <= 1'b0;
            end else if (sel_q && (count_q == COUNT_MAX)) begin
              value_q <= COUNT_MAX;
              len_q   <= len_inc_s;
              err_q   <= 1'b1;
              state_q <= S_DONE;
              done_q  <= 1'b1;
              ready_q <= 1'b0;
            end else begin
              count_q <= count_inc_s;
            end
          end else begin
            count_q <= count_q;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unary_binary_decode.sv
// Self-checking bench for unary_binary_decode: directed table, corner sequences,
// and randomized decodes checked against an arithmetic reference model.
module tb_unary_binary_decode;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_i;
  logic [2:0] cMax;
  logic       sel;
  logic       bin_i;
  logic       bin_valid_i;
  logic       bin_ready_o;
  logic [7:0] Value_o;
  logic [8:0] Bin_length_o;
  logic       Done_o;
  logic       busy_o;
  logic       err_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  unary_binary_decode #(.VALUE_WIDTH(8), .CMAX_WIDTH(3), .LEN_WIDTH(9)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .cMax(cMax), .sel(sel),
    .bin_i(bin_i), .bin_valid_i(bin_valid_i), .bin_ready_o(bin_ready_o),
    .Value_o(Value_o), .Bin_length_o(Bin_length_o), .Done_o(Done_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  typedef struct {
    logic       s;
    logic [2:0] cm;
    int         ones;
    int         ev;
    int         el;
    int         ee;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference: value is the leading-one count, capped at cMax (TRU) or 255 (unary)
  function automatic void model(input logic s, input int cm, input int ones,
                                output int v, output int l, output int e);
    e = 0;
    if (!s) begin
      if (cm == 0)          begin v = 0;    l = 0;        end
      else if (ones >= cm)  begin v = cm;   l = cm;       end
      else                  begin v = ones; l = ones + 1; end
    end else begin
      if (ones >= 256)      begin v = 255;  l = 256; e = 1; end
      else                  begin v = ones; l = ones + 1;   end
    end
  endfunction

  task automatic check_all_zero(input string name);
    check({name, " Value_o"},      Value_o,      0);
    check({name, " Bin_length_o"}, Bin_length_o, 0);
    check({name, " Done_o"},       Done_o,       0);
    check({name, " bin_ready_o"},  bin_ready_o,  0);
    check({name, " busy_o"},       busy_o,       0);
    check({name, " err_o"},        err_o,        0);
  endtask

  // Drives one decode: a stream of 'ones' 1-bins followed by a held 0
  task automatic run_decode(input string name, input logic s, input logic [2:0] cm,
                            input int ones, input int ev, input int el, input int ee,
                            input int stall_pct, input int stall_at, input int pulse_at);
    int idx = 0;
    int cycles = 0;
    int stall_left = 0;
    bit stall_used = 1'b0;
    bit pulse_used = 1'b0;
    bit acc;
    @(negedge clk);
    start_i = 1'b1; sel = s; cMax = cm; bin_valid_i = 1'b0; bin_i = 1'b0;
    @(negedge clk);
    start_i = 1'b0; sel = 1'($urandom); cMax = 3'($urandom);
    check({name, " ready_t1"}, bin_ready_o, (!s && cm == 3'd0) ? 0 : 1);
    while (!Done_o && cycles < 2000) begin
      bin_i = (idx < ones);
      if (idx == stall_at && !stall_used) begin
        stall_left = 2;
        stall_used = 1'b1;
      end
      if (stall_left > 0) begin
        bin_valid_i = 1'b0;
        stall_left--;
      end else begin
        bin_valid_i = ($urandom_range(99) >= stall_pct);
      end
      if (idx == pulse_at && !pulse_used) begin
        start_i = 1'b1; sel = 1'b0; cMax = 3'd0;
        pulse_used = 1'b1;
      end
      acc = bin_valid_i && bin_ready_o;
      @(negedge clk);
      start_i = 1'b0;
      if (acc) idx++;
      cycles++;
    end
    bin_valid_i = 1'b0;
    check({name, " done_seen"},    (cycles < 2000) ? 1 : 0, 1);
    check({name, " Value_o"},      Value_o,      ev);
    check({name, " Bin_length_o"}, Bin_length_o, el);
    check({name, " err_o"},        err_o,        ee);
    check({name, " consumed"},     idx,          el);
    check({name, " ready_done"},   bin_ready_o,  0);
    check({name, " busy_done"},    busy_o,       1);
  endtask

  initial begin
    int v, l, e, ones;
    logic s;
    logic [2:0] cm;

    tbl[0] = '{1'b0, 3'd3, 2,   2,   3,   0};
    tbl[1] = '{1'b0, 3'd3, 3,   3,   3,   0};
    tbl[2] = '{1'b1, 3'd0, 7,   7,   8,   0};
    tbl[3] = '{1'b0, 3'd0, 4,   0,   0,   0};
    tbl[4] = '{1'b1, 3'd5, 300, 255, 256, 1};
    tbl[5] = '{1'b1, 3'd2, 0,   0,   1,   0};
    tbl[6] = '{1'b0, 3'd7, 6,   6,   7,   0};
    tbl[7] = '{1'b0, 3'd7, 9,   7,   7,   0};
    tbl[8] = '{1'b0, 3'd1, 0,   0,   1,   0};
    tbl[9] = '{1'b0, 3'd1, 1,   1,   1,   0};

    rst_n = 1'b0; start_i = 1'b0; cMax = 3'd0; sel = 1'b0;
    bin_i = 1'b0; bin_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_decode($sformatf("tbl%0d", i), tbl[i].s, tbl[i].cm, tbl[i].ones,
                 tbl[i].ev, tbl[i].el, tbl[i].ee, 0, -1, -1);
    end

    run_decode("stall_unary", 1'b1, 3'd0, 7, 7, 8, 0, 0, 3, -1);
    run_decode("overflow_pulse", 1'b1, 3'd0, 256, 255, 256, 1, 20, -1, 128);

    // start_i in the DONE cycle must be ignored
    start_i = 1'b1; sel = 1'b0; cMax = 3'd0;
    @(negedge clk);
    start_i = 1'b0;
    check("done_start Done_o", Done_o, 0);
    check("done_start busy_o", busy_o, 0);
    @(negedge clk);
    check("done_start idle busy_o", busy_o, 0);
    check("done_start idle Done_o", Done_o, 0);

    // reset in the middle of a unary decode
    start_i = 1'b1; sel = 1'b1; cMax = 3'd0;
    @(negedge clk);
    start_i = 1'b0; bin_i = 1'b1; bin_valid_i = 1'b1;
    repeat (2) @(negedge clk);
    bin_valid_i = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("mid_reset");
    rst_n = 1'b1;
    run_decode("after_reset", 1'b1, 3'd0, 0, 0, 1, 0, 0, -1, -1);

    for (int i = 0; i < 40; i++) begin
      s  = 1'($urandom);
      cm = 3'($urandom);
      ones = ($urandom_range(9) == 0) ? int'($urandom_range(270, 250))
                                      : int'($urandom_range(9, 0));
      model(s, int'(cm), ones, v, l, e);
      run_decode($sformatf("rand%0d", i), s, cm, ones, v, l, e, 30, -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
